// File: rtl/bipad_hdx_ctrl_pkg.sv
// bipad_hdx_ctrl_pkg: shared state encoding, defaults and counter sizing for the half-duplex pad controller
package bipad_hdx_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, TX, TURN, RX, RESP} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TURN_CYCLES = 2;
  function automatic int cnt_width(input int width, input int turn);
    return $clog2(width > turn ? width : turn) + 1;
  endfunction
endpackage

// File: rtl/bipad_hdx_shreg.sv
// bipad_hdx_shreg: loadable shift register, shifts left taking sin_i into the LSB
module bipad_hdx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sh_q;
  always_ff @(posedge clk)
    if (rst) sh_q <= '0;
    else if (load_i) sh_q <= data_i;
    else if (shift_i) sh_q <= {sh_q[WIDTH-2:0], sin_i};
  assign q_o = sh_q;
endmodule

// File: rtl/bipad_hdx_ctrl.sv
// bipad_hdx_ctrl: fabric-side half-duplex driver for a bipad cell (TX word, turnaround, optional RX word)
module bipad_hdx_ctrl
  import bipad_hdx_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  (* clkbuf_sink *) input logic CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_DATA,
  input  logic             REQ_RX,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             PAD_A,
  output logic             PAD_EN,
  input  logic             PAD_Q,
  output logic             BUSY
);
  localparam int CW = cnt_width(WIDTH, TURN_CYCLES);
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("TURN_CYCLES must be at least 1");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic rx_flag_q, rsp_valid_q;
  logic [WIDTH-1:0] tx_q, rx_q;
  logic accept, unused_tx;
  assign accept = (state_q == IDLE) && REQ_VALID;
  bipad_hdx_shreg #(.WIDTH(WIDTH)) u_tx (
    .clk(CLK), .rst(RST), .load_i(accept), .data_i(REQ_DATA),
    .shift_i(state_q == TX), .sin_i(1'b0), .q_o(tx_q)
  );
  bipad_hdx_shreg #(.WIDTH(WIDTH)) u_rx (
    .clk(CLK), .rst(RST), .load_i(1'b0), .data_i('0),
    .shift_i(state_q == RX), .sin_i(PAD_Q), .q_o(rx_q)
  );
  assign unused_tx = ^tx_q[WIDTH-2:0];
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rx_flag_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (REQ_VALID) begin
          state_q <= TX;
          cnt_q <= '0;
          rx_flag_q <= REQ_RX;
        end
        TX: begin
          cnt_q <= (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
          state_q <= (cnt_q == CW'(WIDTH - 1)) ? TURN : TX;
        end
        TURN: begin
          cnt_q <= (cnt_q == CW'(TURN_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
          if (cnt_q == CW'(TURN_CYCLES - 1)) state_q <= rx_flag_q ? RX : IDLE;
        end
        RX: begin
          cnt_q <= (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: if (RSP_READY) begin
          state_q <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  // the RX register only shifts in RX, so it already holds the reply stable through RESP
  assign RSP_DATA = rx_q;
  assign RSP_VALID = rsp_valid_q;
  assign REQ_READY = state_q == IDLE;
  assign BUSY = state_q != IDLE;
  assign PAD_EN = state_q == TX;
  assign PAD_A = (state_q == TX) & tx_q[WIDTH-1];
endmodule
